regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_rr.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and register index.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int REG_N  = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

endpackage : cpu_types_pkg

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin grant for register-file writeback requesters.
// Latency: 0 cycles (grant is combinational from req/hold); last_grant updates on the granting edge.
// Backpressure: hold or reset forces gnt to 0; a requester not granted simply keeps requesting.
//
// Ports:
//   CLK, nRST   clock, asynchronous active-low reset
//   req[1:0]    per-requester valid
//   hold        suppress all grants this cycle
//   gnt[1:0]    one-hot (or zero) grant; a grant is always a completed transfer
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       hold,
    output logic [1:0] gnt
);

    // 1 = requester 1 was granted most recently. Resets to 1 so requester 0
    // wins the first contention.
    logic last_grant_q;
    logic last_grant_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        gnt = 2'b00;
        // Grants are combinational, so they must also be masked while reset is
        // held; otherwise a requester could see ready during reset.
        if (nRST && !hold) begin
            if (req == 2'b11) begin
                gnt = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // A grant only happens when the matching req is high, so any grant is a
    // completed transfer and is the only thing that moves the pointer.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt[1]) begin
            last_grant_d = 1'b1;
        end else if (gnt[0]) begin
            last_grant_d = 1'b0;
        end
    end

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline WB and multicycle-unit writebacks onto one register-file write port, with a busy scoreboard.
// Latency: 1 cycle from accepted transfer to rf_WEN/rf_wsel/rf_wdat; ready and chk_busy are combinational.
// Backpressure: valid/ready per requester; loser of a contention (or anyone under hold/reset) sees ready=0 and holds its request.
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   reqN_valid/wsel/wdat/ready     writeback request channels (0 = pipeline WB, 1 = multicycle unit)
//   rf_WEN/rf_wsel/rf_wdat         registered register-file write port
//   hold                           stall both requesters this cycle
//   flush                          clear every busy bit
//   rsv_en/rsv_sel                 reserve a destination (mark busy)
//   chk_sel1/2 -> chk_busy1/2      combinational scoreboard lookups
module regfile_wb_arbiter
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     req0_valid,
    input  regbits_t req0_wsel,
    input  word_t    req0_wdat,
    output logic     req0_ready,
    input  logic     req1_valid,
    input  regbits_t req1_wsel,
    input  word_t    req1_wdat,
    output logic     req1_ready,
    output logic     rf_WEN,
    output regbits_t rf_wsel,
    output word_t    rf_wdat,
    input  logic     hold,
    input  logic     flush,
    input  logic     rsv_en,
    input  regbits_t rsv_sel,
    input  regbits_t chk_sel1,
    input  regbits_t chk_sel2,
    output logic     chk_busy1,
    output logic     chk_busy2
);

    logic [1:0] gnt;
    logic       xfer;
    regbits_t   xfer_sel;
    word_t      xfer_dat;

    logic             rf_wen_q,  rf_wen_d;
    regbits_t         rf_wsel_q, rf_wsel_d;
    word_t            rf_wdat_q, rf_wdat_d;
    logic [REG_N-1:0] busy_q,    busy_d;

    rr_arbiter2 u_rr (
        .CLK  (CLK),
        .nRST (nRST),
        .req  ({req1_valid, req0_valid}),
        .hold (hold),
        .gnt  (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    assign xfer     = |gnt;
    assign xfer_sel = gnt[1] ? req1_wsel : req0_wsel;
    assign xfer_dat = gnt[1] ? req1_wdat : req0_wdat;

    // Write port: a transfer to r0 is still a transfer (select/data follow it)
    // but never raises the enable. Idle cycles keep select/data steady.
    always_comb begin
        rf_wen_d  = xfer && (xfer_sel != '0);
        rf_wsel_d = rf_wsel_q;
        rf_wdat_d = rf_wdat_q;
        if (xfer) begin
            rf_wsel_d = xfer_sel;
            rf_wdat_d = xfer_dat;
        end
    end

    // Scoreboard priority, lowest to highest: writeback clear, reservation set,
    // flush. A new producer reserving the register being written back must
    // keep it busy, and a flush discards every pending producer.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[xfer_sel] = 1'b0;
        end
        if (rsv_en && (rsv_sel != '0)) begin
            busy_d[rsv_sel] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rf_wen_q  <= 1'b0;
            rf_wsel_q <= '0;
            rf_wdat_q <= '0;
            busy_q    <= '0;
        end else begin
            rf_wen_q  <= rf_wen_d;
            rf_wsel_q <= rf_wsel_d;
            rf_wdat_q <= rf_wdat_d;
            busy_q    <= busy_d;
        end
    end

    assign rf_WEN  = rf_wen_q;
    assign rf_wsel = rf_wsel_q;
    assign rf_wdat = rf_wdat_q;

    assign chk_busy1 = (chk_sel1 != '0) && busy_q[chk_sel1];
    assign chk_busy2 = (chk_sel2 != '0) && busy_q[chk_sel2];

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus constrained-random traffic against a reference model.
// Latency: model predicts ready/chk_busy in-cycle and the rf write port one cycle after each transfer.
// Backpressure: requesters keep valid/wsel/wdat stable until granted.
module tb_regfile_wb_arbiter;

    logic        CLK;
    logic        nRST;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_wsel,  req1_wsel;
    logic [31:0] req0_wdat,  req1_wdat;
    logic        req0_ready, req1_ready;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic        hold, flush, rsv_en;
    logic [4:0]  rsv_sel, chk_sel1, chk_sel2;
    logic        chk_busy1, chk_busy2;

    regfile_wb_arbiter dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req0_valid (req0_valid),
        .req0_wsel  (req0_wsel),
        .req0_wdat  (req0_wdat),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_wsel  (req1_wsel),
        .req1_wdat  (req1_wdat),
        .req1_ready (req1_ready),
        .rf_WEN     (rf_WEN),
        .rf_wsel    (rf_wsel),
        .rf_wdat    (rf_wdat),
        .hold       (hold),
        .flush      (flush),
        .rsv_en     (rsv_en),
        .rsv_sel    (rsv_sel),
        .chk_sel1   (chk_sel1),
        .chk_sel2   (chk_sel2),
        .chk_busy1  (chk_busy1),
        .chk_busy2  (chk_busy2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [31:0] m_busy;       // one flag per architectural register
    int          m_last;       // which requester won most recently (0/1)
    logic        m_wen;
    logic [4:0]  m_wsel;
    logic [31:0] m_wdat;
    int          step_winner;  // winner of the most recent modelled cycle, -1 if none

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy      = '0;
        m_last      = 1;
        m_wen       = 1'b0;
        m_wsel      = '0;
        m_wdat      = '0;
        step_winner = -1;
    endtask

    // One clock cycle with the inputs currently applied: check the
    // combinational outputs, advance the model across the edge, then check
    // the registered write port.
    task automatic step();
        int          w;
        logic [4:0]  s;
        logic [31:0] d;
        logic        re, fl;
        logic [4:0]  rs;
        #1;
        w = -1;
        if (!hold) begin
            if (req0_valid && req1_valid) w = 1 - m_last;
            else if (req0_valid)          w = 0;
            else if (req1_valid)          w = 1;
        end
        check("req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
        check("chk_busy1", {31'd0, chk_busy1}, {31'd0, m_busy[chk_sel1]});
        check("chk_busy2", {31'd0, chk_busy2}, {31'd0, m_busy[chk_sel2]});
        s  = (w == 1) ? req1_wsel : req0_wsel;
        d  = (w == 1) ? req1_wdat : req0_wdat;
        re = rsv_en;
        rs = rsv_sel;
        fl = flush;
        @(posedge CLK);
        if (w >= 0) begin
            m_wen     = (s != 5'd0);
            m_wsel    = s;
            m_wdat    = d;
            m_busy[s] = 1'b0;
            m_last    = w;
        end else begin
            m_wen = 1'b0;
        end
        if (re && rs != 5'd0) m_busy[rs] = 1'b1;
        if (fl) m_busy = '0;
        step_winner = w;
        #1;
        check("rf_WEN",  {31'd0, rf_WEN}, {31'd0, m_wen});
        check("rf_wsel", {27'd0, rf_wsel}, {27'd0, m_wsel});
        check("rf_wdat", rf_wdat, m_wdat);
    endtask

    // New random request only where the previous one was accepted or absent.
    task automatic drive_random();
        if (!req0_valid || step_winner == 0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_wsel  = 5'($urandom_range(0, 31));
            req0_wdat  = $urandom;
        end
        if (!req1_valid || step_winner == 1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_wsel  = 5'($urandom_range(0, 31));
            req1_wdat  = $urandom;
        end
        hold     = ($urandom_range(0, 7) == 0);
        flush    = ($urandom_range(0, 15) == 0);
        rsv_en   = ($urandom_range(0, 1) == 1);
        rsv_sel  = 5'($urandom_range(0, 31));
        chk_sel1 = 5'($urandom_range(0, 31));
        chk_sel2 = 5'($urandom_range(0, 31));
    endtask

    initial begin
        nRST = 1'b0;
        req0_valid = 1'b0; req0_wsel = '0; req0_wdat = '0;
        req1_valid = 1'b0; req1_wsel = '0; req1_wdat = '0;
        hold = 1'b0; flush = 1'b0; rsv_en = 1'b0; rsv_sel = '0;
        chk_sel1 = '0; chk_sel2 = '0;
        model_reset();

        // Reset state.
        #2;
        check("rst_wen",  {31'd0, rf_WEN}, 32'd0);
        check("rst_wsel", {27'd0, rf_wsel}, 32'd0);
        check("rst_wdat", rf_wdat, 32'd0);
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        #9;
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Single request from the pipeline WB.
        req0_valid = 1'b1; req0_wsel = 5'd5; req0_wdat = 32'hDEADBEEF;
        #1;
        check("single_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        check("single_wen",  {31'd0, rf_WEN}, 32'd1);
        check("single_wsel", {27'd0, rf_wsel}, 32'd5);
        check("single_wdat", rf_wdat, 32'hDEADBEEF);
        req0_valid = 1'b0;

        // Transfer to r0: accepted, but no register write.
        req1_valid = 1'b1; req1_wsel = 5'd0; req1_wdat = 32'h1234;
        step();
        check("r0_wen", {31'd0, rf_WEN}, 32'd0);
        req1_valid = 1'b0;

        // Continuous contention alternates, starting with req0.
        req0_valid = 1'b1; req0_wsel = 5'd1; req0_wdat = 32'hA0A0_0001;
        req1_valid = 1'b1; req1_wsel = 5'd2; req1_wdat = 32'hB0B0_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready0", {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
            step();
            check("rr_wen",  {31'd0, rf_WEN}, 32'd1);
            check("rr_wsel", {27'd0, rf_wsel}, ((i % 2) == 0) ? 32'd1 : 32'd2);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reserve r7, then write it back; then reserve and write back together.
        rsv_en = 1'b1; rsv_sel = 5'd7; chk_sel1 = 5'd7;
        step();
        rsv_en = 1'b0;
        #1;
        check("rsv7_busy", {31'd0, chk_busy1}, 32'd1);
        req0_valid = 1'b1; req0_wsel = 5'd7; req0_wdat = 32'h0000_0777;
        step();
        req0_valid = 1'b0;
        #1;
        check("wb7_clear", {31'd0, chk_busy1}, 32'd0);
        rsv_en = 1'b1; req0_valid = 1'b1;
        step();
        rsv_en = 1'b0; req0_valid = 1'b0;
        #1;
        check("set_wins", {31'd0, chk_busy1}, 32'd1);

        // Hold stalls a request; flush clears the scoreboard.
        rsv_en = 1'b1; rsv_sel = 5'd3;
        step();
        rsv_sel = 5'd9;
        step();
        rsv_en = 1'b0; chk_sel1 = 5'd3; chk_sel2 = 5'd9;
        hold = 1'b1; req0_valid = 1'b1; req0_wsel = 5'd4; req0_wdat = 32'h4444_0004;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ready0", {31'd0, req0_ready}, 32'd0);
            step();
        end
        check("pre_flush3", {31'd0, chk_busy1}, 32'd1);
        check("pre_flush9", {31'd0, chk_busy2}, 32'd1);
        hold = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; req0_valid = 1'b0;
        #1;
        check("flush3", {31'd0, chk_busy1}, 32'd0);
        check("flush9", {31'd0, chk_busy2}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            step();
        end

        // Reset asserted mid-stream with both requesters valid.
        hold = 1'b0; flush = 1'b0;
        rsv_en = 1'b1; rsv_sel = 5'd12; chk_sel1 = 5'd12; chk_sel2 = 5'd13;
        req0_valid = 1'b1; req0_wsel = 5'd20; req0_wdat = 32'h2020_2020;
        req1_valid = 1'b1; req1_wsel = 5'd21; req1_wdat = 32'h2121_2121;
        step();
        rsv_en = 1'b0;
        #1;
        check("pre_rst_busy12", {31'd0, chk_busy1}, 32'd1);
        nRST = 1'b0;
        model_reset();
        #1;
        check("arst_ready0", {31'd0, req0_ready}, 32'd0);
        check("arst_ready1", {31'd0, req1_ready}, 32'd0);
        check("arst_wen",    {31'd0, rf_WEN}, 32'd0);
        check("arst_busy12", {31'd0, chk_busy1}, 32'd0);
        check("arst_wdat",   rf_wdat, 32'd0);
        @(posedge CLK);
        #1;
        check("arst_hold_wen", {31'd0, rf_WEN}, 32'd0);
        nRST = 1'b1;
        #1;
        check("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
        check("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
        step();

        for (int i = 0; i < 200; i++) begin
            drive_random();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
